// File: rtl/pocket_spi_rx.sv
// pocket_spi_rx: oversampled 2-bit SPI target that assembles bytes into fixed-length commands
module pocket_spi_rx #(
  parameter int SYNC = 2,
  parameter int CMDB = 8,
  parameter int TOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_ss,
  input  logic [1:0]        spi_d,
  output logic [7:0]        dout,
  output logic              dout_ok,
  output logic [8*CMDB-1:0] cmd,
  output logic              cmd_ok,
  output logic              err,
  output logic              busy
);
  localparam int CW = 8 * CMDB;
  localparam int BW = $clog2(CMDB + 1);
  localparam int TW = $clog2(TOUT + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [SYNC:0] clk_p;
  logic [SYNC-1:0] ss_p;
  logic [SYNC-1:0][1:0] d_p;
  logic [1:0] cnt, cnt_n, d_s;
  logic [5:0] sr, sr_n;
  logic [7:0] byte_n;
  logic [CW-1:0] cmd_sr, cmd_nxt;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic ss_s, rise, byte_done, fsm_err, tout_hit;
  // Synchronisers are data-only; the core reset does not need to touch them.
  always_ff @(posedge clk) begin
    clk_p <= {clk_p[SYNC-1:0], spi_clk};
    ss_p  <= {ss_p[SYNC-2:0], spi_ss};
    d_p   <= {d_p[SYNC-2:0], spi_d};
  end
  assign ss_s = ss_p[SYNC-1];
  assign d_s = d_p[SYNC-1];
  assign rise = clk_p[SYNC-1] & ~clk_p[SYNC];
  assign byte_n = {d_s, sr};
  assign cmd_nxt = (cmd_sr << 8) | CW'(byte_n);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    byte_done = 1'b0;
    fsm_err = 1'b0;
    if (state == IDLE) begin
      if (!ss_s) begin
        state_n = SHIFT;
        cnt_n = 2'd0;
      end
    end else if (ss_s) begin
      state_n = IDLE;
      fsm_err = cnt != 2'd0;
      cnt_n = 2'd0;
    end else if (rise) begin
      sr_n = {d_s, sr[5:2]};
      cnt_n = cnt + 2'd1;
      byte_done = cnt == 2'd3;
    end
  end
  assign tout_hit = bcnt != '0 && tcnt == TW'(TOUT - 1) && !byte_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      dout <= '0;
      dout_ok <= 1'b0;
      cmd_sr <= '0;
      cmd <= '0;
      cmd_ok <= 1'b0;
      bcnt <= '0;
      tcnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      dout_ok <= byte_done;
      cmd_ok <= byte_done && bcnt == BW'(CMDB - 1);
      err <= fsm_err | tout_hit;
      if (byte_done) begin
        dout <= byte_n;
        cmd_sr <= cmd_nxt;
        bcnt <= bcnt == BW'(CMDB - 1) ? '0 : bcnt + BW'(1);
        if (bcnt == BW'(CMDB - 1)) cmd <= cmd_nxt;
      end else if (tout_hit) bcnt <= '0;
      tcnt <= (byte_done || tout_hit) ? '0 : (bcnt != '0 && tcnt != TW'(TOUT)) ? tcnt + TW'(1) : tcnt;
    end
  end
  assign busy = (state == SHIFT && cnt != 2'd0) || bcnt != '0;
endmodule

// File: tb/tb_pocket_spi_rx.sv
// tb_pocket_spi_rx: directed scenarios for the 2-bit SPI receiver and command assembler
module tb_pocket_spi_rx;
  localparam int TOUT = 4096;
  logic clk = 0, rst = 1, spi_clk = 0, spi_ss = 1;
  logic [1:0] spi_d = 0;
  logic [7:0] dout;
  logic [63:0] cmd;
  logic dout_ok, cmd_ok, err, busy;
  int tests = 0, fails = 0;
  int n_dok = 0, n_cok = 0, n_err = 0, n_busy = 0, n_lone = 0;
  logic [7:0] last_dout = 0;
  logic [63:0] last_cmd = 0;

  pocket_spi_rx #(.SYNC(2), .CMDB(8), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_d(spi_d),
    .dout(dout), .dout_ok(dout_ok), .cmd(cmd), .cmd_ok(cmd_ok), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_ok) begin n_dok++; last_dout = dout; end
    if (cmd_ok) begin n_cok++; last_cmd = cmd; if (!dout_ok) n_lone++; end
    if (err) n_err++;
    if (busy) n_busy++;
  end

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_pair(input logic [1:0] p);
    spi_d = p;
    spi_clk = 0;
    wait_clk(8);
    spi_clk = 1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_ss = 0;
    wait_clk(4);
    for (int i = 0; i < 4; i++) send_pair(b[2*i +: 2]);
    spi_clk = 0;
    wait_clk(4);
    spi_ss = 1;
    wait_clk(8);
  endtask

  task automatic send_cmd(input logic [63:0] c);
    for (int i = 7; i >= 0; i--) send_byte(c[8*i +: 8]);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    wait_clk(6);
    tests++;
    if ({dout, dout_ok, cmd, cmd_ok, err, busy} !== 76'd0) begin
      fails++;
      $display("FAIL reset: dout=%h dout_ok=%b cmd=%h cmd_ok=%b err=%b busy=%b expected all 0", dout, dout_ok, cmd, cmd_ok, err, busy);
    end
    rst = 0;
    wait_clk(4);
  endtask

  task automatic test_byte;
    int d0 = n_dok, e0 = n_err;
    send_byte(8'hA5);
    tests++;
    if (last_dout !== 8'hA5) begin fails++; $display("FAIL byte_a5: got %h expected a5", last_dout); end
    tests++;
    if (n_dok - d0 !== 1) begin fails++; $display("FAIL byte_a5_ok: got %0d strobes expected 1", n_dok - d0); end
    tests++;
    if (n_err - e0 !== 0) begin fails++; $display("FAIL byte_a5_err: got %0d expected 0", n_err - e0); end
  endtask

  task automatic test_partial;
    int d0 = n_dok, e0 = n_err;
    spi_ss = 0;
    wait_clk(4);
    send_pair(2'b11);
    send_pair(2'b10);
    spi_clk = 0;
    wait_clk(4);
    spi_ss = 1;
    wait_clk(8);
    tests++;
    if (n_dok - d0 !== 0) begin fails++; $display("FAIL partial_ok: got %0d strobes expected 0", n_dok - d0); end
    tests++;
    if (n_err - e0 !== 1) begin fails++; $display("FAIL partial_err: got %0d err cycles expected 1", n_err - e0); end
    send_byte(8'h3C);
    tests++;
    if (last_dout !== 8'h3C) begin fails++; $display("FAIL after_partial: got %h expected 3c", last_dout); end
  endtask

  task automatic test_timeout;
    int e0, c0;
    send_byte(8'h77);
    e0 = n_err;
    c0 = n_cok;
    wait_clk(TOUT + 10);
    tests++;
    if (n_err - e0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d err cycles expected 1", n_err - e0); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    send_cmd(64'hF800_0000_1234_5678);
    tests++;
    if (n_cok - c0 !== 1) begin fails++; $display("FAIL cmd_count: got %0d expected 1", n_cok - c0); end
    check("cmd_value", last_cmd, 64'hF800_0000_1234_5678);
    tests++;
    if (n_lone !== 0) begin fails++; $display("FAIL cmd_coincident: got %0d lone cmd_ok expected 0", n_lone); end
  endtask

  task automatic test_rst_mid;
    int e0, c0;
    for (int i = 1; i <= 5; i++) send_byte(8'(8'h90 + i));
    e0 = n_err;
    rst = 1;
    wait_clk(1);
    rst = 0;
    tests++;
    if ({dout, dout_ok, cmd, cmd_ok, err, busy} !== 76'd0) begin
      fails++;
      $display("FAIL rst_mid: dout=%h cmd=%h busy=%b err=%b expected all 0", dout, cmd, busy, err);
    end
    wait_clk(4);
    c0 = n_cok;
    send_cmd(64'h2122_2324_2526_2728);
    tests++;
    if (n_err - e0 !== 0) begin fails++; $display("FAIL rst_mid_err: got %0d expected 0", n_err - e0); end
    tests++;
    if (n_cok - c0 !== 1) begin fails++; $display("FAIL rst_mid_cmd_count: got %0d expected 1", n_cok - c0); end
    check("rst_mid_cmd", last_cmd, 64'h2122_2324_2526_2728);
  endtask

  task automatic test_ss_high;
    int d0 = n_dok, e0 = n_err, b0 = n_busy;
    spi_ss = 1;
    for (int i = 0; i < 8; i++) send_pair(2'(i));
    spi_clk = 0;
    wait_clk(8);
    tests++;
    if (n_dok - d0 !== 0) begin fails++; $display("FAIL ss_high_ok: got %0d expected 0", n_dok - d0); end
    tests++;
    if (n_err - e0 !== 0) begin fails++; $display("FAIL ss_high_err: got %0d expected 0", n_err - e0); end
    tests++;
    if (n_busy - b0 !== 0) begin fails++; $display("FAIL ss_high_busy: got %0d busy cycles expected 0", n_busy - b0); end
  endtask

  initial begin
    test_reset;
    test_byte;
    test_partial;
    test_timeout;
    test_rst_mid;
    test_ss_high;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
